mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  - CPU-side initiator for the word-addressed data memory (ports readmode/writemode/address/dataIn/dataOut).
//  - Accepts byte/half/word loads and stores from the MEM stage over a valid/ready handshake.
//  - Converts byte addresses to word indices and sequences one-cycle read/write strobe pulses.
//  - Performs read-modify-write for sub-word stores, since the memory is word-only.
// PARAMETERS
//  - MEM_WORDS  512  depth of the attached data memory, in 32-bit words
//  - RD_WAIT    1    cycles readmode is held high before mem_dataOut is sampled (>=1)
// PORTS
//  - clk            in   1   single clock, all state on rising edge
//  - rst_n          in   1   asynchronous active-low reset
//  - req_valid      in   1   request present
//  - req_ready      out  1   unit can accept; high only in IDLE
//  - req_we         in   1   1=store, 0=load
//  - req_size       in   2   00 byte, 01 half, 10 word, 11 reserved (treated as word)
//  - req_signed     in   1   loads: sign-extend (1) / zero-extend (0)
//  - req_addr       in   32  byte address
//  - req_wdata      in   32  store data, right-justified
//  - resp_valid     out  1   one-cycle pulse: access complete; no backpressure
//  - resp_rdata     out  32  extended load data, valid with resp_valid; 0 for stores
//  - resp_err       out  1   access fault, valid with resp_valid (0 unless MEM_ACCESS_CHECK_EN)
//  - mem_address    out  32  word index = {2'b00, req_addr[31:2]}
//  - mem_dataIn     out  32  word to write
//  - mem_readmode   out  1   read strobe
//  - mem_writemode  out  1   write strobe
//  - mem_dataOut    in   32  word read from memory
// BEHAVIOUR
//  - Reset (async): state IDLE, req_ready=1; all other outputs 0.
//  - Handshake: request accepted on a clk edge with req_valid & req_ready; all fields registered.
//  - Strobes: readmode and writemode never high together; each returns to 0 between accesses
//    (the memory acts on strobe edges). mem_address/mem_dataIn are stable while a strobe is high.
//  - FSM IDLE -> RD -> RESP          load
//        IDLE -> WR -> RESP          word store
//        IDLE -> RD -> WR -> RESP    byte/half store (RMW)
//        RESP -> IDLE                always
//  - RD: readmode=1 for RD_WAIT cycles (down-counter); mem_dataOut captured on the last cycle.
//  - WR: writemode=1 for exactly 1 cycle.
//  - Latency from accept edge T:
//      load:             resp_valid at T+RD_WAIT+1
//      word store:       resp_valid at T+2
//      sub-word store:   resp_valid at T+RD_WAIT+2
//    Back-to-back requests have one IDLE cycle between them.
//  - Byte lanes are big-endian: byte offset 0 = bits[31:24], offset 3 = bits[7:0].
//    Half offset 0 = [31:16], offset 2 = [15:0].
//  - Sub-word alignment: half uses addr[1] only (addr[0] ignored); word ignores addr[1:0].
//  - Store merge: only the selected lane of the read word is replaced by req_wdata[7:0] or [15:0].
//  - Load extract: selected lane right-justified, sign- or zero-extended to 32 bits.
//  - Reset asserted mid-operation: strobes drop at once and the FSM returns to IDLE.
//    The in-flight request is lost (no response); the pipeline must reissue it.
// CONFIGURATION
//  - MEM_ACCESS_CHECK_EN defined:
//      - Misaligned half (addr[0]=1) or word (addr[1:0]!=0) raises a fault.
//      - So does word index >= MEM_WORDS.
//      - On fault: IDLE -> RESP directly, no strobe issued, resp_err=1, resp_rdata=0.
//  - MEM_ACCESS_CHECK_EN undefined:
//      - No checks; low bits ignored as above; resp_err tied 0.
//      - Index is not range-limited.
// STRUCTURE
//  - Package mem_access_pkg:
//      - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
//      - FSM state enum (IDLE, RD, WR, RESP)
//  - Sub-module mem_lane_align (combinational): store-merge and load-extract/extend from
//    (word, offset, size, signed, wdata).
// TESTING
//  - Word store 0xDEADBEEF @0x10, then word load @0x10
//      -> writemode pulse at address 4; then rdata=0xDEADBEEF at T+2 (RD_WAIT=1).
//  - Word 0x11223344 @0x20, sb 0xAA @0x22, lw @0x20
//      -> one read then one write pulse; rdata=0x1122AA44.
//  - Word 0x80F07F01 @0x0
//      - lb @0x0 -> 0xFFFFFF80; lbu @0x0 -> 0x00000080
//      - lh @0x2 -> 0x00007F01; lh @0x0 -> 0xFFFF80F0
//  - req_valid held high for 3 loads
//      -> req_ready low outside IDLE; exactly 3 resp_valid pulses, in order.
//    Check every cycle that readmode & writemode is never 1.
//  - rst_n low during RD of a load
//      -> strobes 0 asynchronously, no resp_valid; req_ready=1 after release.
//  - With MEM_ACCESS_CHECK_EN: lw @0x6 and lw @0x800 (MEM_WORDS=512)
//      -> resp_err=1 at T+1, no strobe issued.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory access unit: request size encodings
// and the sequencing FSM states.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RESP = 2'b11
    } state_t;

    // The reserved size code behaves exactly like a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'b11) ? SZ_WORD : size;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian byte lane handling for a word-only memory: merges sub-word
// store data into a read word and extracts/extends sub-word load data.
// Byte offset 0 is bits [31:24]; half offset 0 (addr[1]=0) is bits [31:16].
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_signed,
    input  logic [31:0] wdata,
    output logic [31:0] merged,
    output logic [31:0] extracted
);

    logic [4:0]  byte_lsb;
    logic [4:0]  half_lsb;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Inverting the offset gives the lane position counted from the LSB end.
    assign byte_lsb  = {~offset, 3'b000};
    assign half_lsb  = {~offset[1], 4'b0000};
    assign byte_lane = word[byte_lsb +: 8];
    assign half_lane = word[half_lsb +: 16];

    // Replace only the selected lane for stores; right-justify and extend for loads.
    always_comb begin
        merged    = word;
        extracted = word;
        case (size)
            SZ_BYTE: begin
                merged[byte_lsb +: 8] = wdata[7:0];
                extracted = {{24{is_signed & byte_lane[7]}}, byte_lane};
            end
            SZ_HALF: begin
                merged[half_lsb +: 16] = wdata[15:0];
                extracted = {{16{is_signed & half_lane[15]}}, half_lane};
            end
            default: begin
                merged    = wdata;
                extracted = word;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// CPU-side initiator for a word-addressed data memory. Accepts byte/half/word
// loads and stores over a valid/ready handshake, issues one-cycle-spaced
// read/write strobes and performs read-modify-write for sub-word stores.
// Optional feature: define MEM_ACCESS_CHECK_EN to fault misaligned accesses
// and word indices at or beyond MEM_WORDS (no strobe, resp_err=1).
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int MEM_WORDS = 512,
    parameter int RD_WAIT   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_dataIn,
    output logic        mem_readmode,
    output logic        mem_writemode,
    input  logic [31:0] mem_dataOut
);

    localparam int CNT_W = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;

`ifdef MEM_ACCESS_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    state_t            state;
    logic              we_q;
    logic              signed_q;
    logic [1:0]        size_q;
    logic [1:0]        offset_q;
    logic [31:0]       wdata_q;
    logic [CNT_W-1:0]  rd_cnt;
    logic [1:0]        size_in;
    logic              misaligned;
    logic              out_of_range;
    logic              fault;
    logic [31:0]       merged;
    logic [31:0]       extracted;

    assign size_in = norm_size(req_size);

    // Fault detection on the incoming request; only honoured when checking is built in.
    always_comb begin
        misaligned = 1'b0;
        case (size_in)
            SZ_HALF: misaligned = req_addr[0];
            SZ_WORD: misaligned = |req_addr[1:0];
            default: misaligned = 1'b0;
        endcase
        out_of_range = ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));
        fault        = CHECK_EN & (misaligned | out_of_range);
    end

    mem_lane_align u_align (
        .word      (mem_dataOut),
        .offset    (offset_q),
        .size      (size_q),
        .is_signed (signed_q),
        .wdata     (wdata_q),
        .merged    (merged),
        .extracted (extracted)
    );

    // Access sequencer: every output is registered so strobes are glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            resp_err      <= 1'b0;
            mem_address   <= '0;
            mem_dataIn    <= '0;
            mem_readmode  <= 1'b0;
            mem_writemode <= 1'b0;
            we_q          <= 1'b0;
            signed_q      <= 1'b0;
            size_q        <= SZ_BYTE;
            offset_q      <= '0;
            wdata_q       <= '0;
            rd_cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready   <= 1'b0;
                        we_q        <= req_we;
                        signed_q    <= req_signed;
                        size_q      <= size_in;
                        offset_q    <= req_addr[1:0];
                        wdata_q     <= req_wdata;
                        mem_address <= {2'b00, req_addr[31:2]};
                        if (fault) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                            state      <= RESP;
                        end else if (req_we && size_in == SZ_WORD) begin
                            mem_dataIn    <= req_wdata;
                            mem_writemode <= 1'b1;
                            state         <= WR;
                        end else begin
                            mem_readmode <= 1'b1;
                            rd_cnt       <= CNT_W'(RD_WAIT - 1);
                            state        <= RD;
                        end
                    end
                end
                RD: begin
                    if (rd_cnt == '0) begin
                        mem_readmode <= 1'b0;
                        if (we_q) begin
                            mem_dataIn    <= merged;
                            mem_writemode <= 1'b1;
                            state         <= WR;
                        end else begin
                            resp_rdata <= extracted;
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end
                    end else begin
                        rd_cnt <= rd_cnt - 1'b1;
                    end
                end
                WR: begin
                    mem_writemode <= 1'b0;
                    resp_rdata    <= '0;
                    resp_valid    <= 1'b1;
                    state         <= RESP;
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, back-to-back
// and reset-abort sequences, then randomized accesses against a byte-array model.
// Honours MEM_ACCESS_CHECK_EN for fault expectations.
module tb_mem_access_unit;

    localparam int MEM_WORDS = 512;
    localparam int RD_WAIT   = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_dataIn;
    logic        mem_readmode;
    logic        mem_writemode;
    logic [31:0] mem_dataOut;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.MEM_WORDS(MEM_WORDS), .RD_WAIT(RD_WAIT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_size      (req_size),
        .req_signed    (req_signed),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .mem_address   (mem_address),
        .mem_dataIn    (mem_dataIn),
        .mem_readmode  (mem_readmode),
        .mem_writemode (mem_writemode),
        .mem_dataOut   (mem_dataOut)
    );

    // Word-only memory attached to the DUT.
    logic [31:0] mem [MEM_WORDS];
    assign mem_dataOut = mem[mem_address[8:0]];
    always @(posedge clk) begin
        if (mem_writemode) mem[mem_address[8:0]] <= mem_dataIn;
    end

    // Strobe activity monitor.
    int          rd_pulses = 0;
    int          wr_pulses = 0;
    int          rd_cycles = 0;
    int          wr_cycles = 0;
    int          overlap   = 0;
    logic        prev_rd   = 1'b0;
    logic        prev_wr   = 1'b0;
    logic [31:0] last_wr_addr = 32'hFFFF_FFFF;
    always @(negedge clk) begin
        if (mem_readmode && mem_writemode) overlap++;
        if (mem_readmode) rd_cycles++;
        if (mem_writemode) begin
            wr_cycles++;
            last_wr_addr = mem_address;
        end
        if (mem_readmode && !prev_rd) rd_pulses++;
        if (mem_writemode && !prev_wr) wr_pulses++;
        prev_rd = mem_readmode;
        prev_wr = mem_writemode;
    end

    // Reference model: memory as a flat big-endian byte array.
    logic [7:0] ref_bytes [MEM_WORDS*4];

    function automatic int lane_count(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic int first_byte(input logic [31:0] a, input logic [1:0] sz);
        int n = lane_count(sz);
        return int'((a % (MEM_WORDS * 4)) / n * n);
    endfunction

    function automatic bit model_fault(input logic [31:0] a, input logic [1:0] sz);
`ifdef MEM_ACCESS_CHECK_EN
        if ((a / 4) >= MEM_WORDS) return 1'b1;
        if (a % lane_count(sz) != 0) return 1'b1;
        return 1'b0;
`else
        return (a === 32'hx) && (sz === 2'bx);
`endif
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic sgn);
        int n = lane_count(sz);
        int fb = first_byte(a, sz);
        logic [31:0] v = 32'h0;
        for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_bytes[fb + i]);
        if (sgn && n < 4 && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
        return v;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        int n = lane_count(sz);
        int fb = first_byte(a, sz);
        for (int i = 0; i < n; i++) ref_bytes[fb + i] = 8'(wd >> (8 * (n - 1 - i)));
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Issues one request and waits (bounded) for its response.
    task automatic apply_stimulus(input string tag, input logic we, input logic [1:0] size, input logic sgn,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  output logic [31:0] rdata, output logic err, output int lat,
                                  output int rdp, output int wrp, output int rdc, output int wrc);
        int rp0, wp0, rc0, wc0;
        bit got = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        check_output({tag, ".ready"}, 32'(req_ready), 32'd1);
        rp0 = rd_pulses; wp0 = wr_pulses; rc0 = rd_cycles; wc0 = wr_cycles;
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; rdata = 32'h0; err = 1'b0;
        for (int n = 1; n <= 20 && !got; n++) begin
            @(negedge clk);
            if (resp_valid) begin
                got = 1'b1;
                lat = n;
                rdata = resp_rdata;
                err = resp_err;
            end
        end
        if (!got) check_output({tag, ".timeout"}, 32'd0, 32'd1);
        rdp = rd_pulses - rp0; wrp = wr_pulses - wp0;
        rdc = rd_cycles - rc0; wrc = wr_cycles - wc0;
    endtask

    // Runs one access and compares everything against the model.
    task automatic run_op(input string tag, input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input bit use_tbl, input logic [31:0] tbl_rdata);
        logic [31:0] rdata, exp_rdata;
        logic err;
        int lat, rdp, wrp, rdc, wrc, exp_lat, exp_rdp, exp_wrp;
        bit flt = model_fault(addr, size);
        exp_rdata = (!we && !flt) ? model_load(addr, size, sgn) : 32'h0;
        if (use_tbl) exp_rdata = tbl_rdata;
        if (flt) begin
            exp_lat = 1; exp_rdp = 0; exp_wrp = 0;
        end else if (!we) begin
            exp_lat = RD_WAIT + 1; exp_rdp = 1; exp_wrp = 0;
        end else if (lane_count(size) == 4) begin
            exp_lat = 2; exp_rdp = 0; exp_wrp = 1;
        end else begin
            exp_lat = RD_WAIT + 2; exp_rdp = 1; exp_wrp = 1;
        end
        apply_stimulus(tag, we, size, sgn, addr, wdata, rdata, err, lat, rdp, wrp, rdc, wrc);
        if (we && !flt) model_store(addr, size, wdata);
        check_output({tag, ".rdata"}, rdata, exp_rdata);
        check_output({tag, ".err"}, 32'(err), 32'(flt));
        check_output({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        check_output({tag, ".rdpulse"}, 32'(rdp), 32'(exp_rdp));
        check_output({tag, ".wrpulse"}, 32'(wrp), 32'(exp_wrp));
        check_output({tag, ".rdcyc"}, 32'(rdc), 32'(exp_rdp * RD_WAIT));
        check_output({tag, ".wrcyc"}, 32'(wrc), 32'(exp_wrp));
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [31:0] b2b_addr [3];
        logic [1:0]  b2b_size [3];
        logic        b2b_sgn  [3];
        logic [31:0] b2b_exp  [3];
        logic [31:0] got_q [$];
        int          cyc_q [$];
        int          idx, viol, resp_seen;

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        for (int i = 0; i < MEM_WORDS; i++) begin
            mem[i] = $urandom;
            for (int b = 0; b < 4; b++) ref_bytes[4 * i + b] = 8'(mem[i] >> (8 * (3 - b)));
        end

        // Reset state
        #12;
        check_output("rst.ready", 32'(req_ready), 32'd1);
        check_output("rst.resp_valid", 32'(resp_valid), 32'd0);
        check_output("rst.strobes", {30'd0, mem_readmode, mem_writemode}, 32'd0);
        check_output("rst.address", mem_address, 32'd0);
        check_output("rst.rdata", resp_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table
        vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF});
        vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, 32'h0});
        vecs.push_back('{1'b1, 2'd0, 1'b0, 32'h22, 32'h000000AA, 32'h0});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h1122AA44});
        vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h00, 32'h80F07F01, 32'h0});
        vecs.push_back('{1'b0, 2'd0, 1'b1, 32'h00, 32'h0, 32'hFFFFFF80});
        vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h00, 32'h0, 32'h00000080});
        vecs.push_back('{1'b0, 2'd1, 1'b1, 32'h02, 32'h0, 32'h00007F01});
        vecs.push_back('{1'b0, 2'd1, 1'b1, 32'h00, 32'h0, 32'hFFFF80F0});
        vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h00, 32'h0, 32'h000080F0});
        vecs.push_back('{1'b1, 2'd1, 1'b0, 32'h12, 32'hFFFF1234, 32'h0});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEAD1234});
        vecs.push_back('{1'b0, 2'd0, 1'b1, 32'h23, 32'h0, 32'h00000044});
        vecs.push_back('{1'b0, 2'd0, 1'b1, 32'h22, 32'h0, 32'hFFFFFFAA});
        vecs.push_back('{1'b1, 2'd3, 1'b0, 32'h30, 32'hCAFEF00D, 32'h0});
        vecs.push_back('{1'b0, 2'd3, 1'b0, 32'h30, 32'h0, 32'hCAFEF00D});
`ifdef MEM_ACCESS_CHECK_EN
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h06, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h800, 32'h0, 32'h0});
`else
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h13, 32'h0, 32'hDEAD1234});
        vecs.push_back('{1'b0, 2'd1, 1'b1, 32'h03, 32'h0, 32'h00007F01});
`endif
        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].we, vecs[i].size, vecs[i].sgn,
                   vecs[i].addr, vecs[i].wdata, 1'b1, vecs[i].exp_rdata);
            if (i == 0) check_output("vec0.wr_addr", last_wr_addr, 32'd4);
        end

        // Back-to-back loads with req_valid held high
        b2b_addr = '{32'h100, 32'h106, 32'h10B};
        b2b_size = '{2'd2, 2'd1, 2'd0};
        b2b_sgn  = '{1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 3; k++) b2b_exp[k] = model_load(b2b_addr[k], b2b_size[k], b2b_sgn[k]);
        idx = 0; viol = 0;
        @(negedge clk);
        for (int cyc = 0; cyc < 40 && got_q.size() < 3; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (resp_valid) begin
                got_q.push_back(resp_rdata);
                cyc_q.push_back(cyc);
            end
            if (req_ready && (resp_valid || mem_readmode || mem_writemode)) viol++;
            if (req_valid && idx == 3 && !req_ready) req_valid = 1'b0;
            if (req_ready && idx < 3) begin
                req_valid  = 1'b1;
                req_we     = 1'b0;
                req_size   = b2b_size[idx];
                req_signed = b2b_sgn[idx];
                req_addr   = b2b_addr[idx];
                idx++;
            end
        end
        req_valid = 1'b0;
        check_output("b2b.count", 32'(got_q.size()), 32'd3);
        check_output("b2b.ready_viol", 32'(viol), 32'd0);
        for (int k = 0; k < 3; k++) begin
            check_output($sformatf("b2b.rdata%0d", k), (k < got_q.size()) ? got_q[k] : 32'hx, b2b_exp[k]);
        end
        for (int k = 1; k < 3; k++) begin
            check_output($sformatf("b2b.gap%0d", k), (k < cyc_q.size()) ? 32'(cyc_q[k] - cyc_q[k - 1]) : 32'hx,
                         32'(RD_WAIT + 2));
        end

        // Reset asserted while a load is reading
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h40;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check_output("abort.rd_before", 32'(mem_readmode), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_output("abort.strobes", {30'd0, mem_readmode, mem_writemode}, 32'd0);
        check_output("abort.ready", 32'(req_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        resp_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid) resp_seen++;
        end
        check_output("abort.no_resp", 32'(resp_seen), 32'd0);
        check_output("abort.ready_after", 32'(req_ready), 32'd1);

        // Randomized accesses against the byte model
        for (int i = 0; i < 150; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 32'h8FF));
            run_op($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), a, $urandom, 1'b0, 32'h0);
        end

        check_output("strobe_overlap", 32'(overlap), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
